// File: rtl/pwm_if.sv
// Duty request in, waveform and period strobe out, for one PWM channel.
// The slave modport is the PWM core; the master modport is whatever supplies the duty.
interface pwm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DUTY_CYCLE;
  logic             PWM_OUT;
  logic             PERIOD_START;

  modport master (
    output DUTY_CYCLE,
    input  PWM_OUT,
    input  PERIOD_START
  );

  modport slave (
    input  DUTY_CYCLE,
    output PWM_OUT,
    output PERIOD_START
  );
endinterface

// File: rtl/pwm.sv
// Fixed-frequency PWM. The duty word is double-buffered at the period wrap, so the
// output waveform changes shape only on a period boundary and never glitches mid-period.
module pwm #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  pwm_if.slave bus
);

  localparam int               PDW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PDW-1:0]   PDIV_LAST = PDW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST  = '1;

  logic [PDW-1:0]   pdiv_q, pdiv_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             tick;
  logic             wrap;

  // Output level for a counter position; unsigned compare, so no saturation is possible.
  function automatic logic duty_high(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] duty);
    return (cnt < duty);
  endfunction

  assign tick = (pdiv_q == PDIV_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  always_comb begin
    pdiv_d = tick ? '0 : pdiv_q + PDW'(1);
    cnt_d  = tick ? cnt_q + WIDTH'(1) : cnt_q;
    duty_d = wrap ? bus.DUTY_CYCLE : duty_q;
    // Compare the values being written this edge so the registered pin equals (cnt < duty) now.
    pwm_d  = duty_high(cnt_d, duty_d);
    ps_d   = wrap;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pdiv_q <= '0;
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      pdiv_q <= pdiv_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      ps_q   <= ps_d;
    end
  end

  assign bus.PWM_OUT      = pwm_q;
  assign bus.PERIOD_START = ps_q;

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: one instance with PRESCALE=1, one with PRESCALE=4.
// Every cycle of each period is compared against the ideal (k < duty) waveform.
module tb_pwm;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  pwm_if #(.WIDTH(W)) b1 ();
  pwm_if #(.WIDTH(W)) b4 ();

  pwm #(.WIDTH(W), .PRESCALE(1)) u1 (.CLK(clk), .RST(rst),  .bus(b1));
  pwm #(.WIDTH(W), .PRESCALE(4)) u4 (.CLK(clk), .RST(rst4), .bus(b4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks len cycles of one PRESCALE=1 period starting at its first cycle (k=0).
  // Optionally drives a new duty word after sampling cycle chg_at.
  task automatic run_period(input string tag, input int duty, input logic ps0,
                            input int len, input int chg_at, input int chg_val);
    int   hi;
    int   bad;
    logic ps_first;
    hi       = 0;
    bad      = 0;
    ps_first = 1'bx;
    for (int k = 0; k < len; k++) begin
      if (k == 0) ps_first = b1.PERIOD_START;
      if (b1.PWM_OUT !== logic'(k < duty)) bad++;
      if (k > 0 && b1.PERIOD_START !== 1'b0) bad++;
      if (b1.PWM_OUT === 1'b1) hi++;
      if (k == chg_at) b1.DUTY_CYCLE = W'(chg_val);
      step();
    end
    chk({tag, "_ps"}, ps_first, ps0);
    chk({tag, "_high"}, hi, (duty < len) ? duty : len);
    chk({tag, "_shape"}, bad, 0);
  endtask

  initial begin
    int          hi;
    int          bad;
    logic [W-1:0] exp_d;
    logic [W-1:0] next_d;
    logic [W-1:0] nd;

    rst  = 1'b1;
    rst4 = 1'b1;
    b1.DUTY_CYCLE = '0;
    b4.DUTY_CYCLE = W'(1);
    step();
    step();
    chk("rst_pwm1", b1.PWM_OUT, 0);
    chk("rst_ps1",  b1.PERIOD_START, 0);
    chk("rst_pwm4", b4.PWM_OUT, 0);
    chk("rst_ps4",  b4.PERIOD_START, 0);

    // First period after release is always low; 128 is sampled at its wrap.
    b1.DUTY_CYCLE = W'(128);
    rst = 1'b0;
    run_period("first",   0,   1'b0, 256, -1, 0);
    run_period("d128_a",  128, 1'b1, 256, -1, 0);
    run_period("d128_b",  128, 1'b1, 256, 0,  0);
    run_period("d0_a",    0,   1'b1, 256, -1, 0);
    run_period("d0_b",    0,   1'b1, 256, -1, 0);
    run_period("d0_c",    0,   1'b1, 256, -1, 0);
    run_period("d0_d",    0,   1'b1, 256, 0,  255);
    run_period("d255_a",  255, 1'b1, 256, -1, 0);
    run_period("d255_b",  255, 1'b1, 256, 0,  64);
    // Mid-period change at cnt=100 must not disturb the running period.
    run_period("d64",     64,  1'b1, 256, 100, 192);
    run_period("d192",    192, 1'b1, 256, 0,  200);
    run_period("d200",    200, 1'b1, 256, -1, 0);

    // Reset pulse at cnt=30 with duty 200 in force.
    run_period("pre_rst", 200, 1'b1, 30, -1, 0);
    rst = 1'b1;
    step();
    chk("midrst_pwm", b1.PWM_OUT, 0);
    chk("midrst_ps",  b1.PERIOD_START, 0);
    rst = 1'b0;
    run_period("post_rst",  0,   1'b0, 256, -1, 0);
    run_period("resume200", 200, 1'b1, 256, -1, 0);

    // Duty changes every cycle; only the value at the wrap edge (k=255) counts.
    exp_d  = W'(200);
    next_d = W'(200);
    for (int p = 0; p < 50; p++) begin
      hi  = 0;
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        if (b1.PWM_OUT !== logic'(k < int'(exp_d))) bad++;
        if (b1.PERIOD_START !== logic'(k == 0)) bad++;
        if (b1.PWM_OUT === 1'b1) hi++;
        nd = W'($urandom_range(0, 255));
        b1.DUTY_CYCLE = nd;
        if (k == 255) next_d = nd;
        step();
      end
      chk("rand_high",  hi, int'(exp_d));
      chk("rand_shape", bad, 0);
      exp_d = next_d;
    end

    // PRESCALE=4, duty 1: 1024-cycle period, 4 high cycles after each strobe.
    rst4 = 1'b1;
    step();
    chk("p4_rst_pwm", b4.PWM_OUT, 0);
    rst4 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      hi  = 0;
      bad = 0;
      for (int k = 0; k < 1024; k++) begin
        if (b4.PWM_OUT !== logic'(p > 0 && k < 4)) bad++;
        if (b4.PERIOD_START !== logic'(p > 0 && k == 0)) bad++;
        if (b4.PWM_OUT === 1'b1) hi++;
        step();
      end
      chk("p4_high",  hi, (p > 0) ? 4 : 0);
      chk("p4_shape", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm.md
# pwm

Fixed-frequency pulse-width modulator. Converts an unsigned duty word into a square wave whose high time per period is proportional to the word. It feeds actuator drivers such as a fan or motor stage, and takes its duty either from a control register or directly from a measured rate such as a tachometer count. Duty updates are double-buffered so that every output period is glitch-free.

## Interface
Parameters:
- WIDTH, 8: bit width of the duty word and period counter; the period is 2^WIDTH counter steps.
- PRESCALE, 1: CLK cycles per counter step; legal range 1..65535.

Ports:
- CLK  input  1  single clock; all state changes on its rising edge.
- RST  input  1  reset, synchronous and active-high.
- DUTY_CYCLE  input  WIDTH  requested high time, in counter steps per period; unsigned.
- PWM_OUT  output  1  registered PWM waveform.
- PERIOD_START  output  1  one-cycle registered strobe marking the first cycle of each new period.

## Operation
- Prescaler `pdiv` counts 0..PRESCALE-1 and wraps.
  - `tick` = (pdiv == PRESCALE-1).
  - With PRESCALE=1, tick is high every cycle.
- Period counter `cnt` (WIDTH bits) increments on tick and wraps 2^WIDTH-1 -> 0 with no stall.
- Shadow register `duty_q` (WIDTH bits) loads DUTY_CYCLE only on the edge where tick && cnt == 2^WIDTH-1, which is the wrap edge.
  - DUTY_CYCLE is ignored on every other edge.
  - Mid-period changes therefore never affect the current period.
- PWM_OUT is registered. On every edge it loads (cnt_next < duty_q_next), using the values being written on that same edge.
  - As a result, PWM_OUT == (cnt < duty_q) holds in every cycle after reset, with no combinational path to the pin.
- Resulting duty: high for duty_q*PRESCALE cycles, then low for (2^WIDTH - duty_q)*PRESCALE cycles.
  - duty 0 gives constant low.
  - duty 2^WIDTH-1 gives high for all but one step; 100% is not reachable by design.
- PERIOD_START is set on the wrap edge (the same edge that loads duty_q) and cleared on all other edges. It is high exactly in the cycle where cnt == 0 and pdiv == 0 following a wrap.
- No arithmetic saturation is needed: the comparison is unsigned and WIDTH-bit.

## Timing
- Reset (RST high at an edge): pdiv=0, cnt=0, duty_q=0, PWM_OUT=0, PERIOD_START=0. RST dominates all other activity.
- First period after reset release:
  - duty_q = 0, so PWM_OUT stays low for 2^WIDTH*PRESCALE cycles.
  - DUTY_CYCLE is first sampled at the end of this period.
  - PERIOD_START is not asserted at reset release; its first assertion follows the first wrap.
- Latency:
  - A DUTY_CYCLE value present on the wrap edge appears on PWM_OUT in the next cycle, the first cycle of the new period.
  - A value presented anywhere else takes effect at the following wrap, up to one full period later.
- Period = 2^WIDTH * PRESCALE CLK cycles, exact and jitter-free.
- RST asserted mid-period: PWM_OUT drops low on that edge and the counters restart from 0. Duty is lost and reverts to 0 until the next wrap.
- DUTY_CYCLE may change every cycle with no handshake. Only its value at the wrap edge matters.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Reset, then DUTY_CYCLE=128, PRESCALE=1:
  - PWM_OUT=0 for cycles 0..255.
  - Then alternating 128 high / 128 low.
  - PERIOD_START pulses every 256 cycles, coincident with the first high cycle.
- DUTY_CYCLE=0 held: PWM_OUT never asserts over 4 periods. DUTY_CYCLE=255 held: 255 high, 1 low per period.
- DUTY_CYCLE=64, then changed to 192 at cnt=100: the current period keeps 64 high; the next period has 192 high.
- PRESCALE=4, DUTY_CYCLE=1: period 1024 cycles, PWM_OUT high for exactly 4 cycles after each PERIOD_START.
- RST pulsed for one cycle at cnt=30 with duty=200:
  - PWM_OUT=0 from the next cycle.
  - Low for 256 cycles, then the 200-high pattern resumes.
- Randomized DUTY_CYCLE changing each cycle over 50 periods: the high count per period equals DUTY_CYCLE sampled at the preceding wrap edge, and PWM_OUT shows no single-cycle glitches within a period.
